// File: rtl/ssram_reader_pkg.sv
// Shared types and constants for the SSRAM stream reader.
// FSM state encoding and skid buffer sizing.
package ssram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ssram_reader_skid.sv
// Two-entry skid buffer: entry 0 is always the head,
// so the output comes straight from a register.
module ssram_reader_skid
    import ssram_reader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     e0_q, e0_d;
    logic [W-1:0]     e1_q, e1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == '0) e0_d = din;
                else             e1_d = din;
                cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - CNT_W'(1);
            end
            2'b11: begin
                // Simultaneous push and pop keeps occupancy unchanged
                if (cnt_q == CNT_W'(1)) begin
                    e0_d = din;
                end else begin
                    e0_d = e1_q;
                    e1_d = din;
                end
            end
            default: ;
        endcase
    end

    assign dout  = e0_q;
    assign count = cnt_q;

endmodule

// File: rtl/ssram_stream_reader.sv
// Burst reader: streams words from a 1-cycle-latency SSRAM port.
// Define SSRAM_READER_BYTE_SWAP_EN to byte-reverse words at dataOut.
module ssram_stream_reader
    import ssram_reader_pkg::*;
#(
    parameter  int bitwidth    = 32,
    parameter  int nrOfEntries = 512,
    localparam int AW          = $clog2(nrOfEntries)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       startAddress,
    input  logic [AW:0]         burstSize,
    output logic [AW-1:0]       ramAddress,
    input  logic [bitwidth-1:0] ramData,
    output logic [bitwidth-1:0] dataOut,
    output logic                dataValid,
    input  logic                dataReady,
    output logic                busy,
    output logic                done
);

    state_t state_q, state_d;

    logic [AW-1:0]       ptr_q, ptr_d;
    logic [AW:0]         rem_q, rem_d;
    logic [AW:0]         beats_q, beats_d;
    logic                inflight_q, inflight_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    count;
    logic [bitwidth-1:0] head;
    logic                valid;
    logic                pop;
    logic                issue;
    logic [2:0]          occ;

    ssram_reader_skid #(
        .W(bitwidth)
    ) u_skid (
        .clock (clock),
        .reset (reset),
        .push  (inflight_q),
        .din   (ramData),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign valid = (count != '0);
    assign pop   = valid & dataReady;
    assign occ   = 3'(count) + 3'(inflight_q);
    // A read is only counted if its word is guaranteed a skid slot
    assign issue = (state_q == READ) &&
                   (occ < (3'(SKID_DEPTH) + 3'(pop)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            beats_q    <= beats_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        inflight_d = issue;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burstSize == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                        ptr_d   = startAddress;
                        rem_d   = burstSize;
                        beats_d = burstSize;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    ptr_d = (ptr_q == AW'(nrOfEntries - 1)) ?
                            '0 : ptr_q + AW'(1);
                    rem_d = rem_q - (AW+1)'(1);
                    if (rem_q == (AW+1)'(1)) state_d = DRAIN;
                end
                if (pop) beats_d = beats_q - (AW+1)'(1);
            end
            DRAIN: begin
                if (pop) begin
                    beats_d = beats_q - (AW+1)'(1);
                    if (beats_q == (AW+1)'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramAddress = ptr_q;
        dataValid  = valid;
        busy       = (state_q != IDLE);
        done       = done_q;
    end

`ifdef SSRAM_READER_BYTE_SWAP_EN
    if (bitwidth % 8 != 0) begin : g_bad_width
        $error("bitwidth must be a multiple of 8 for byte swap");
    end
    for (genvar b = 0; b < bitwidth / 8; b++) begin : g_swap
        assign dataOut[8*b +: 8] = head[bitwidth-8*(b+1) +: 8];
    end
`else
    assign dataOut = head;
`endif

endmodule
